// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead add/subtract unit with valid/ready on both sides.
// Optional signed saturation is enabled by defining CLA_PIPE_SAT_EN (adds the sat input).
module cla_pipe_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
`ifdef CLA_PIPE_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NG = WIDTH / 4;

  // Stage 1 registers: bit/group propagate-generate terms plus sign info.
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_g;
  logic [NG-1:0]    r_pp;
  logic [NG-1:0]    r_gg;
  logic             r_c0;
  logic             r_a_msb;
  logic             r_bx_msb;
`ifdef CLA_PIPE_SAT_EN
  logic             r_sat;
`endif

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic [WIDTH-1:0] w_bx;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g;
  logic             w_c0;
  logic [NG-1:0]    w_pp;
  logic [NG-1:0]    w_gg;

  logic [NG:0]      w_gc;
  logic [WIDTH-1:0] w_carry;
  logic [WIDTH-1:0] w_sum_raw;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;

  logic             w_adv1;
  logic             w_adv2;
  logic             w_in_hs;
  logic             w_s2_load;

  // Handshake: a transfer happens on a side when valid & ready are both high in the
  // same cycle; valid never waits for ready, ready may depend on out_ready
  // combinationally, and a stage advances whenever its successor is empty or draining.
  assign w_adv2    = ~r_s2_valid | out_ready;
  assign w_adv1    = ~r_s1_valid | w_adv2;
  assign in_ready  = w_adv1;
  assign w_in_hs   = in_valid & w_adv1;
  assign w_s2_load = r_s1_valid & w_adv2;

  always_comb begin
    w_bx = sub ? ~b : b;
    w_c0 = sub | cin;
    w_p  = a ^ w_bx;
    w_g  = a & w_bx;
    w_pp = '0;
    w_gg = '0;
    for (int k = 0; k < NG; k++) begin
      w_pp[k] = &w_p[4*k +: 4];
      w_gg[k] = w_g[4*k+3]
              | (w_p[4*k+3] & w_g[4*k+2])
              | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
              | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
    end
  end

  // Group carries ripple across nibbles; each nibble then resolves its own carries.
  always_comb begin
    w_gc    = '0;
    w_carry = '0;
    w_gc[0] = r_c0;
    for (int k = 0; k < NG; k++) begin
      w_gc[k+1] = r_gg[k] | (r_pp[k] & w_gc[k]);
    end
    for (int k = 0; k < NG; k++) begin
      w_carry[4*k]   = w_gc[k];
      w_carry[4*k+1] = r_g[4*k] | (r_p[4*k] & w_gc[k]);
      w_carry[4*k+2] = r_g[4*k+1]
                     | (r_p[4*k+1] & r_g[4*k])
                     | (r_p[4*k+1] & r_p[4*k] & w_gc[k]);
      w_carry[4*k+3] = r_g[4*k+2]
                     | (r_p[4*k+2] & r_g[4*k+1])
                     | (r_p[4*k+2] & r_p[4*k+1] & r_g[4*k])
                     | (r_p[4*k+2] & r_p[4*k+1] & r_p[4*k] & w_gc[k]);
    end
    w_sum_raw = r_p ^ w_carry;
    w_ovf     = (r_a_msb == r_bx_msb) & (w_sum_raw[WIDTH-1] != r_a_msb);
    w_sum     = w_sum_raw;
`ifdef CLA_PIPE_SAT_EN
    if (r_sat & w_ovf) begin
      w_sum = r_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_p        <= '0;
      r_g        <= '0;
      r_pp       <= '0;
      r_gg       <= '0;
      r_c0       <= 1'b0;
      r_a_msb    <= 1'b0;
      r_bx_msb   <= 1'b0;
`ifdef CLA_PIPE_SAT_EN
      r_sat      <= 1'b0;
`endif
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      if (w_adv1) r_s1_valid <= in_valid;
      if (w_adv2) r_s2_valid <= r_s1_valid;
      if (w_in_hs) begin
        r_p      <= w_p;
        r_g      <= w_g;
        r_pp     <= w_pp;
        r_gg     <= w_gg;
        r_c0     <= w_c0;
        r_a_msb  <= a[WIDTH-1];
        r_bx_msb <= w_bx[WIDTH-1];
`ifdef CLA_PIPE_SAT_EN
        r_sat    <= sat;
`endif
      end
      if (w_s2_load) begin
        r_sum  <= w_sum;
        r_cout <= w_gc[NG];
        r_ovf  <= w_ovf;
        r_zero <= ~|w_sum;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Two-stage pipelined WIDTH-bit add/subtract unit with a valid/ready handshake on input and output.
- Stage 1 produces per-bit propagate/generate and the per-nibble group propagate/generate terms consumed by the 4-bit lookahead carry unit.
- Stage 2 resolves the group carries across nibbles, the in-nibble carries and the sum, then presents the result with flags.
- Sits between the operand-select logic and the ALU result mux.

Parameters:
- WIDTH, 32, operand/result width; multiple of 4, range 8..64; NG = WIDTH/4 nibble groups.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  stage 1 can accept this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  1 = A - B, 0 = A + B
- cin  input  1  carry-in for add; ignored when sub=1
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB (for sub: 1 = no borrow)
- ovf  output  1  two's-complement signed overflow
- zero  output  1  sum == 0

Behaviour:
- Reset is synchronous, active-high. On a clock edge with rst=1, both stage valid bits clear, so out_valid=0. sum, cout, ovf and zero reset to 0. in_ready=1 in the first cycle after reset.
- rst during operation discards both stages' contents; there is no partial completion.
- Effective operands: bx = sub ? ~b : b; c0 = sub ? 1 : cin.
- Stage 1 register, loaded on an input handshake (in_valid & in_ready), holds:
  - p = a ^ bx and g = a & bx (WIDTH bits each);
  - per nibble k: PP[k] = &p[4k+3:4k] and GG[k] = g3 | p3g2 | p3p2g1 | p3p2p1g0;
  - c0, a[MSB] and bx[MSB].
- Stage 2 register, loaded when stage 1 is valid and stage 2 is empty or draining:
  - C[0] = c0; C[k+1] = GG[k] | PP[k]&C[k];
  - in-nibble carries use the 4-bit lookahead equations with C[k] as carry-in;
  - sum = p ^ carries; cout = C[NG];
  - ovf = (a_msb == bx_msb) & (sum_msb != a_msb);
  - zero = ~|sum.
- The functional requirement is exact: {cout,sum} = a + bx + c0 modulo 2^(WIDTH+1).
- Handshake:
  - adv2 = ~s2_valid | out_ready;
  - adv1 = ~s1_valid | adv2;
  - in_ready = adv1, which is combinational from out_ready and the valid bits;
  - stage-2 valid is set when s1_valid & adv2; otherwise it is cleared on out_ready.
- Latency is 2 cycles from the input handshake to out_valid. Throughput is 1 result per cycle while out_ready=1.
- Backpressure: with out_ready=0 the pipeline holds at most 2 operations. in_ready drops only when both stages are valid and out_ready=0.
- Result outputs and out_valid remain stable while out_valid=1 & out_ready=0.
- A simultaneous input and output handshake in one cycle is legal and loses no data.
- in_valid=0 cycles create bubbles that are squeezed out when backpressure is applied.
- Order of results equals order of accepted inputs.

Optional Feature:
- Macro: CLA_PIPE_SAT_EN.
- When defined:
  - adds input sat (1 bit), captured with the operands;
  - when sat=1 and ovf=1, sum is clamped to the signed max (0x7FFF_FFFF for WIDTH=32) if a_msb=0, else to the signed min (0x8000_0000);
  - ovf still reports the raw overflow; zero reflects the clamped sum;
  - handshake and latency are unchanged.
- When undefined: there is no sat port, and sum is always the wrapped result.

Test Plan:
- Reset: hold rst=1 for 2 cycles while in_valid=1 -> out_valid=0, sum=0; after release, in_ready=1 and the first result appears exactly 2 cycles after the first handshake.
- Add, full carry chain: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> sum=0, cout=1, zero=1, ovf=0.
- Signed overflow: a=0x7FFF_FFFF, b=1, add -> sum=0x8000_0000, ovf=1, cout=0. Subtract: a=5, b=7 -> sum=0xFFFF_FFFE, cout=0, ovf=0.
- Backpressure: stream 4 ops with out_ready=0 -> in_ready falls after 2 accepted; raising out_ready drains results in order with no loss or duplication; simultaneous in/out handshake verified.
- Random: 10k random a/b/sub/cin with random in_valid/out_ready against a reference model of {cout,sum} and the flags; WIDTH=8 and WIDTH=64 builds included.
- Saturation (CLA_PIPE_SAT_EN, sat=1): a=0x8000_0000, b=1, sub=1 -> sum=0x8000_0000, ovf=1; the same stimulus with sat=0 -> sum=0x7FFF_FFFF.
